// File: rtl/calc2_port_engine.sv
// calc2_port_engine: calc2 responder port, two-cycle request capture, in-order queue, multi-cycle ALU, tagged response
module calc2_port_engine #(
  parameter int DEPTH     = 4,
  parameter int ADD_LAT   = 3,
  parameter int SHIFT_LAT = 6
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req_cmd_in,
  input  logic [31:0] req_data_in,
  input  logic [1:0]  req_tag_in,
  output logic [1:0]  out_resp,
  output logic [31:0] out_data,
  output logic [1:0]  out_tag,
  output logic        drop_err
);
  localparam logic CAP_IDLE = 1'b0;
  localparam logic CAP_OP2  = 1'b1;
  localparam logic EX_IDLE  = 1'b0;
  localparam logic EX_BUSY  = 1'b1;
  localparam int PW   = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int MAXL = ADD_LAT > SHIFT_LAT ? ADD_LAT : SHIFT_LAT;
  localparam int LW   = $clog2(MAXL + 1);
  logic          cap_state;
  logic [3:0]    cap_cmd;
  logic [1:0]    cap_tag;
  logic [31:0]   cap_op1;
  logic          ex_state;
  logic [LW-1:0] ex_cnt;
  logic [69:0]   ex_ent;
  logic [69:0]   q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] q_cnt;
  logic          new_valid;
  logic [69:0]   new_ent;
  logic          done;
  logic          free;
  logic          pop;
  logic          direct;
  logic          push;
  logic          drop;
  logic          start;
  logic [69:0]   start_ent;
  logic [LW-1:0] start_lat;
  logic [3:0]    ecmd;
  logic [31:0]   op1;
  logic [31:0]   op2;
  logic [32:0]   sum;
  logic          under;
  logic [1:0]    res_resp;
  logic [31:0]   res_data;
  always_comb begin
    new_valid = cap_state == CAP_OP2;
    new_ent   = {cap_cmd, cap_tag, cap_op1, req_data_in};
    done      = ex_state == EX_BUSY && ex_cnt == LW'(1);
    // a finishing unit counts as free so the next command starts on the same edge
    free      = ex_state == EX_IDLE || done;
    pop       = done && q_cnt != '0;
    direct    = new_valid && free && q_cnt == '0;
    push      = new_valid && !direct && (q_cnt != CW'(DEPTH) || pop);
    drop      = new_valid && !direct && !push;
    start     = pop || direct;
    start_ent = pop ? q[head] : new_ent;
    start_lat = (start_ent[69:66] == 4'd5 || start_ent[69:66] == 4'd6) ? LW'(SHIFT_LAT) : LW'(ADD_LAT);
    ecmd      = ex_ent[69:66];
    op1       = ex_ent[63:32];
    op2       = ex_ent[31:0];
    sum       = {1'b0, op1} + {1'b0, op2};
    under     = op2 > op1;
    res_resp  = ecmd == 4'd1 ? (sum[32] ? 2'd2 : 2'd1) :
                ecmd == 4'd2 ? (under ? 2'd2 : 2'd1) :
                (ecmd == 4'd5 || ecmd == 4'd6) ? 2'd1 : 2'd2;
    res_data  = ecmd == 4'd1 ? (sum[32] ? 32'd0 : sum[31:0]) :
                ecmd == 4'd2 ? (under ? 32'd0 : op1 - op2) :
                ecmd == 4'd5 ? op1 << op2[4:0] :
                ecmd == 4'd6 ? op1 >> op2[4:0] : 32'd0;
  end
  always_ff @(posedge c_clk) begin
    if (push) q[tail] <= new_ent;
  end
  always_ff @(posedge c_clk) begin
    if (reset) begin
      cap_state <= CAP_IDLE;
      cap_cmd   <= '0;
      cap_tag   <= '0;
      cap_op1   <= '0;
      ex_state  <= EX_IDLE;
      ex_cnt    <= '0;
      ex_ent    <= '0;
      head      <= '0;
      tail      <= '0;
      q_cnt     <= '0;
      out_resp  <= '0;
      out_data  <= '0;
      out_tag   <= '0;
      drop_err  <= 1'b0;
    end else begin
      cap_state <= (cap_state == CAP_IDLE && req_cmd_in != 4'd0) ? CAP_OP2 : CAP_IDLE;
      if (cap_state == CAP_IDLE) begin
        cap_cmd <= req_cmd_in;
        cap_tag <= req_tag_in;
        cap_op1 <= req_data_in;
      end
      if (push) tail <= tail == PW'(DEPTH - 1) ? '0 : tail + PW'(1);
      if (pop) head <= head == PW'(DEPTH - 1) ? '0 : head + PW'(1);
      q_cnt <= q_cnt + CW'(push) - CW'(pop);
      if (start) begin
        ex_state <= EX_BUSY;
        ex_ent   <= start_ent;
        ex_cnt   <= start_lat;
      end else if (done) begin
        ex_state <= EX_IDLE;
      end else if (ex_state == EX_BUSY) begin
        ex_cnt <= ex_cnt - LW'(1);
      end
      out_resp <= done ? res_resp : 2'd0;
      out_data <= done ? res_data : 32'd0;
      out_tag  <= done ? ex_ent[65:64] : 2'd0;
      drop_err <= drop_err | drop;
    end
  end
endmodule

// File: tb/tb_calc2_port_engine.sv
// tb_calc2_port_engine: randomized and directed check of calc2_port_engine against a timing/arith reference model
module tb_calc2_port_engine;
  localparam int DEPTH = 2;
  localparam int ADD_LAT = 3;
  localparam int SHIFT_LAT = 6;
  typedef struct {
    int          e;
    logic [1:0]  r;
    logic [31:0] d;
    logic [1:0]  t;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cmd = '0;
  logic [31:0] data = '0;
  logic [1:0]  tag = '0;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic        drop_err;
  int          cyc = 0;
  logic        rst_d = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;
  exp_t        expq[$];
  int          starts[$];
  int          last_fin = 0;
  int          drop_at = 32'h7fffffff;
  calc2_port_engine #(.DEPTH(DEPTH), .ADD_LAT(ADD_LAT), .SHIFT_LAT(SHIFT_LAT)) dut (
    .c_clk(clk), .reset(reset), .req_cmd_in(cmd), .req_data_in(data), .req_tag_in(tag),
    .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag), .drop_err(drop_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_d <= reset;
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got %0h want %0h (cycle %0d)", name, got, want, cyc);
  endtask
  function automatic void model(input logic [3:0] c, input logic [1:0] t, input logic [31:0] a, input logic [31:0] b, input int e);
    int occ = 0;
    int s;
    int lat;
    logic [63:0] sum;
    exp_t x;
    foreach (starts[i]) if (starts[i] > e) occ++;
    if (occ >= DEPTH) begin
      if (drop_at > e) drop_at = e;
      return;
    end
    s = e > last_fin ? e : last_fin;
    lat = (c == 4'd5 || c == 4'd6) ? SHIFT_LAT : ADD_LAT;
    last_fin = s + lat;
    starts.push_back(s);
    sum = 64'(a) + 64'(b);
    x.e = s + lat;
    x.t = t;
    case (c)
      4'd1: begin x.r = sum > 64'hFFFFFFFF ? 2'd2 : 2'd1; x.d = sum > 64'hFFFFFFFF ? 32'd0 : sum[31:0]; end
      4'd2: begin x.r = b > a ? 2'd2 : 2'd1; x.d = b > a ? 32'd0 : a - b; end
      4'd5: begin x.r = 2'd1; x.d = a << b[4:0]; end
      4'd6: begin x.r = 2'd1; x.d = a >> b[4:0]; end
      default: begin x.r = 2'd2; x.d = 32'd0; end
    endcase
    expq.push_back(x);
  endfunction
  always @(negedge clk) begin
    if (rst_d) begin
      check("rst_resp", 32'(out_resp), 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_tag", 32'(out_tag), 32'd0);
      check("rst_drop", 32'(drop_err), 32'd0);
    end else if (!reset) begin
      if (expq.size() > 0 && expq[0].e <= cyc) begin
        check("resp_cycle", cyc, expq[0].e);
        check("resp", 32'(out_resp), 32'(expq[0].r));
        check("data", out_data, expq[0].d);
        check("tag", 32'(out_tag), 32'(expq[0].t));
        void'(expq.pop_front());
      end else begin
        check("idle_resp", 32'(out_resp), 32'd0);
        check("idle_data", out_data, 32'd0);
        check("idle_tag", 32'(out_tag), 32'd0);
      end
      check("drop_err", 32'(drop_err), 32'(cyc >= drop_at));
    end
  end
  task automatic send(input logic [3:0] c, input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    cmd = c;
    tag = t;
    data = a;
    @(negedge clk);
    cmd = 4'($urandom_range(0, 15));
    tag = 2'($urandom);
    data = b;
    model(c, t, a, b, cyc + 1);
  endtask
  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      cmd = '0;
      data = $urandom;
    end
  endtask
  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    reset = 1'b1;
    cmd = '0;
    expq.delete();
    starts.delete();
    last_fin = 0;
    drop_at = 32'h7fffffff;
    repeat (n) @(negedge clk);
    #1;
    reset = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && expq.size() > 0; i++) gap(1);
    check("drain_left", expq.size(), 0);
    gap(3);
  endtask
  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction
  function automatic logic [3:0] rnd_cmd();
    case ($urandom_range(0, 4))
      0: return 4'd1;
      1: return 4'd2;
      2: return 4'd5;
      3: return 4'd6;
      default: return 4'($urandom_range(1, 15));
    endcase
  endfunction
  initial begin
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    send(4'd1, 2'd1, 32'h30, 32'h20);
    drain();
    send(4'd1, 2'd2, 32'hFFFFFFFF, 32'h1);
    drain();
    send(4'd2, 2'd3, 32'h10, 32'h20);
    drain();
    send(4'd2, 2'd0, 32'h20, 32'h20);
    drain();
    send(4'd5, 2'd1, 32'h1, 32'h24);
    drain();
    send(4'd6, 2'd2, 32'h80000000, 32'd31);
    drain();
    send(4'd5, 2'd0, 32'h3, 32'h2);
    send(4'd1, 2'd1, 32'h5, 32'h6);
    send(4'd3, 2'd2, 32'h7, 32'h8);
    drain();
    for (int i = 0; i < 5; i++) send(4'd5, 2'(i), 32'(i + 1), 32'd1);
    drain();
    send(4'd5, 2'd0, 32'h1, 32'h1);
    send(4'd5, 2'd1, 32'h2, 32'h1);
    send(4'd5, 2'd2, 32'h3, 32'h1);
    do_reset(2);
    gap(12);
    send(4'd1, 2'd3, 32'h30, 32'h20);
    drain();
    for (int i = 0; i < 300; i++) begin
      send(rnd_cmd(), 2'($urandom), rnd32(), rnd32());
      if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 6));
      if (i == 150) begin
        gap(1);
        do_reset(1);
      end
    end
    gap(1);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
